risc16_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit RISC core; drives the ALU (alu_control, alu_src) and consumes its zero flag.

---
 rtl/risc16_ctrl_fsm.sv | 144 ++++++++++++++
 tb/tb_risc16_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit RISC core: sequences DECODE/EXEC/MEM/WB per
// accepted instruction, drives ALU/memory/register strobes, times out stalled memory.
module risc16_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [15:0]      ir_q,
  output logic [2:0]       alu_control,
  output logic             alu_src,
  input  logic             alu_zero,
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_ack,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             branch_taken,
  output logic             jump,
  output logic             pc_write,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t         state, state_n;
  logic [WCW-1:0] wait_cnt, wait_n;
  logic [3:0]     opcode;
  logic           is_r, is_ld, is_st, is_beq, is_bne, is_ill;

  assign opcode = ir_q[15:12];
  assign is_r   = ~opcode[3];
  assign is_ld  = (opcode == 4'b1000);
  assign is_st  = (opcode == 4'b1001);
  assign is_beq = (opcode == 4'b1010);
  assign is_bne = (opcode == 4'b1011);
  assign is_ill = (opcode >= 4'b1101);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      ir_q          <= '0;
      retired_count <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (state == S_IDLE && instr_valid) ir_q <= instr;
      // illegal opcodes also pulse pc_write but do not count as retired
      if (pc_write && !illegal) retired_count <= retired_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_n      = state;
    wait_n       = wait_cnt;
    instr_ready  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    pc_write     = 1'b0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (is_ill) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_n  = S_IDLE;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          state_n = S_WB;
        end else if (is_ld || is_st) begin
          wait_n  = '0;
          state_n = S_MEM;
        end else begin
          // BEQ/BNE/JMP all finish here
          branch_taken = (is_beq && alu_zero) || (is_bne && !alu_zero);
          jump         = !is_beq && !is_bne;
          pc_write     = 1'b1;
          state_n      = S_IDLE;
        end
      end
      S_MEM: begin
        mem_read  = is_ld;
        mem_write = is_st;
        if (mem_ack) begin
          if (is_ld) begin
            state_n = S_WB;
          end else begin
            pc_write = 1'b1;
            state_n  = S_IDLE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          mem_err = 1'b1;
          state_n = S_IDLE;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        pc_write   = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    alu_src     = 1'b0;
    if (state != S_IDLE) begin
      if (is_r) begin
        alu_control = opcode[2:0];
      end else if (is_ld || is_st) begin
        alu_src = 1'b1;
      end else if (is_beq || is_bne) begin
        alu_control = 3'b001;
      end
    end
  end

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// Scoreboard bench: stimulus pushes per-instruction expectations from a table-driven
// model, a negedge monitor pops them whenever the unit retires or faults.
module tb_risc16_ctrl_fsm;
  localparam int T  = 15;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, instr_valid, alu_zero, mem_ack;
  logic [15:0]   instr;
  logic          instr_ready, alu_src, mem_read, mem_write, mem_to_reg, reg_write;
  logic          branch_taken, jump, pc_write, illegal, mem_err;
  logic [15:0]   ir_q;
  logic [2:0]    alu_control;
  logic [CW-1:0] retired_count;

  risc16_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ir_q(ir_q), .alu_control(alu_control), .alu_src(alu_src),
    .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch_taken(branch_taken),
    .jump(jump), .pc_write(pc_write), .illegal(illegal), .mem_err(mem_err),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lat;
    logic [15:0]   ir;
    bit            pcw, rw, m2r, bt, jmp, ill, merr, alu_care, src;
    logic [2:0]    alu;
    int            nrd, nwr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] cnt_ref;
  int            checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: opcode classes and their fixed cycle costs, straight from the opcode table.
  function automatic exp_t model(logic [15:0] ins, bit z, int ack);
    exp_t e;
    int   op;
    e = '{default: 0};
    op = int'(ins[15:12]);
    e.ir = ins;
    e.alu_care = 1;
    if (op <= 7) begin
      e.lat = 3; e.rw = 1; e.pcw = 1; e.alu = 3'(op);
    end else if (op == 8 || op == 9) begin
      e.src = 1; e.alu = 3'd0;
      if (ack == 0) begin
        e.lat = 2 + T; e.merr = 1;
        if (op == 8) e.nrd = T; else e.nwr = T;
      end else if (op == 8) begin
        e.lat = 3 + ack; e.rw = 1; e.m2r = 1; e.pcw = 1; e.nrd = ack;
      end else begin
        e.lat = 2 + ack; e.pcw = 1; e.nwr = ack;
      end
    end else if (op == 10 || op == 11) begin
      e.lat = 2; e.pcw = 1; e.alu = 3'd1;
      e.bt = (op == 10) ? z : !z;
    end else if (op == 12) begin
      e.lat = 2; e.pcw = 1; e.jmp = 1; e.alu_care = 0;
    end else begin
      e.lat = 1; e.pcw = 1; e.ill = 1; e.alu_care = 0;
    end
    return e;
  endfunction

  task automatic issue(logic [15:0] ins, bit z, int ack);
    exp_t e;
    int   prev, t, g;
    e = model(ins, z, ack);
    if (e.pcw && !e.ill) cnt_ref = cnt_ref + 1'b1;
    e.cnt = cnt_ref;
    q.push_back(e);
    prev = done_cnt;
    instr_valid = 1'b1; instr = ins; alu_zero = z;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    if ((ins[15:12] == 4'd8 || ins[15:12] == 4'd9) && ack > 0) begin
      repeat (ack + 1) @(posedge clk);
      #1 mem_ack = 1'b1;
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    t = 0;
    while (done_cnt == prev && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == prev) begin
      checks++; errors++;
      $display("FAIL completion_timeout: instr %h never completed", ins);
      q.delete();
    end
    #1;
    g = $urandom_range(0, 2);
    repeat (g) @(posedge clk);
    if (g > 0) #1;
  endtask

  task automatic issue_rand();
    logic [15:0] ins;
    int          r, ack;
    ins = {4'($urandom_range(0, 15)), 12'($urandom)};
    r = $urandom_range(0, 9);
    ack = (r < 2) ? 0 : (r == 2) ? T : $urandom_range(1, T);
    issue(ins, 1'($urandom_range(0, 1)), ack);
  endtask

  // Monitor
  int   ncyc = 0, acc = 0, nrd = 0, nwr = 0;
  bit   busy = 0, cnt_chk = 0;
  exp_t cur;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      busy = 0; cnt_chk = 0;
    end else begin
      if (cnt_chk) begin
        chk("retired_count", 32'(retired_count), 32'(cur.cnt));
        cnt_chk = 0;
      end
      if (busy) begin
        chk("rd_wr_exclusive", 32'(mem_read & mem_write), 0);
        chk("ready_low_busy", 32'(instr_ready), 0);
        nrd += int'(mem_read);
        nwr += int'(mem_write);
        if (pc_write || mem_err) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got pc_write=%b mem_err=%b expected none", pc_write, mem_err);
          end else begin
            cur = q.pop_front();
            chk("latency", 32'(ncyc - acc), 32'(cur.lat));
            chk("ir_q", 32'(ir_q), 32'(cur.ir));
            chk("strobes", 32'({pc_write, reg_write, mem_to_reg, branch_taken, jump, illegal, mem_err}),
                32'({cur.pcw, cur.rw, cur.m2r, cur.bt, cur.jmp, cur.ill, cur.merr}));
            chk("alu_src", 32'(alu_src), 32'(cur.src));
            if (cur.alu_care) chk("alu_control", 32'(alu_control), 32'(cur.alu));
            chk("mem_read_cycles", 32'(nrd), 32'(cur.nrd));
            chk("mem_write_cycles", 32'(nwr), 32'(cur.nwr));
            cnt_chk = 1;
          end
          busy = 0;
          done_cnt++;
        end else begin
          chk("stray_strobes", 32'({reg_write, mem_to_reg, branch_taken, jump, illegal}), 0);
        end
      end else begin
        chk("idle_ready", 32'(instr_ready), 1);
        chk("idle_outputs", 32'({mem_read, mem_write, pc_write, reg_write, mem_to_reg, branch_taken,
                                 jump, illegal, mem_err, alu_src, alu_control}), 0);
        if (instr_valid) begin
          busy = 1; acc = ncyc; nrd = 0; nwr = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b1; instr = 16'h0123; alu_zero = 1'b0; mem_ack = 1'b0;
    cnt_ref = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_count", 32'(retired_count), 0);
    chk("rst_ir_q", 32'(ir_q), 0);
    chk("rst_outputs", 32'({mem_read, mem_write, pc_write, reg_write, mem_to_reg, branch_taken,
                            jump, illegal, mem_err, alu_src, alu_control}), 0);
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("ir_q_no_accept_in_reset", 32'(ir_q), 0);

    issue(16'h0123, 1'b0, 0);
    issue(16'hA000, 1'b1, 0);
    issue(16'hB000, 1'b1, 0);
    issue(16'h8000, 1'b0, 3);
    issue(16'h9000, 1'b0, 0);
    issue(16'h9000, 1'b0, T);
    issue(16'h8000, 1'b0, T);
    issue(16'hE000, 1'b0, 0);
    issue(16'hC000, 1'b0, 0);
    for (int i = 0; i < 16; i++) issue(16'h0123, 1'b0, 0);
    for (int i = 0; i < 250; i++) issue_rand();

    // Reset while a load sits in MEM
    instr_valid = 1'b1; instr = 16'h8000;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mem_read_before_reset", 32'(mem_read), 1);
    reset = 1'b1;
    #1;
    chk("mem_read_reset_async", 32'(mem_read), 0);
    chk("ready_reset_async", 32'(instr_ready), 1);
    chk("count_reset_async", 32'(retired_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_ref = '0;
    q.delete();
    issue(16'h8000, 1'b0, 2);
    for (int i = 0; i < 10; i++) issue_rand();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
